// File: rtl/gapb4_regs_if_pkg.sv
// gapb4_regs_if_pkg: shared FSM encoding and counter width for the APB register front-end
package gapb4_regs_if_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/gapb4_regs_if_if.sv
// gapb4_regs_if_if: APB4 bus bundle with bridge-side and register-block-side views
interface gapb4_regs_if_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gapb4_regs_if_gmux.sv
// gmux_one_hot_cfg: AND-OR read mux over N words selected by a one-hot vector
module gmux_one_hot_cfg #(
  parameter int DATA_W = 32,
  parameter int N = 8
) (
  input  logic [N-1:0]        sel,
  input  logic [DATA_W*N-1:0] din,
  output logic [DATA_W-1:0]   dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) dout = dout | (din[i*DATA_W +: DATA_W] & {DATA_W{sel[i]}});
  end
endmodule

// File: rtl/gapb4_regs_if.sv
// gapb4_regs_if: APB4 slave front-end decoding per-register strobes, wait states and error response
module gapb4_regs_if
  import gapb4_regs_if_pkg::*;
#(
  parameter int                 REG_NUM  = 8,
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 6,
  parameter int                 WAIT_CYC = 0,
  parameter logic [REG_NUM-1:0] RO_MASK  = '0,
  parameter bit                 ERR_EN   = 1'b1
) (
  input  logic                      pclk,
  input  logic                      rst,
  gapb4_regs_if_if.slave            apb,
  input  logic [DATA_W*REG_NUM-1:0] regs_port,
  output logic [REG_NUM-1:0]        reg_wr_en,
  output logic [DATA_W/8-1:0]       reg_wr_strb,
  output logic [DATA_W-1:0]         reg_wr_data,
  output logic [REG_NUM-1:0]        reg_rd_en
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;
  state_t              state, next;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx_q, idx;
  logic                wr_q, wr;
  logic [DATA_W-1:0]   wdata_q, wdata;
  logic [STRB_W-1:0]   strb_q, strb;
  logic                setup, err, acc;
  logic [REG_NUM-1:0]  sel;
  logic [DATA_W-1:0]   rdata;
  logic                pready_d, pslverr_d;
  logic [REG_NUM-1:0]  wr_en_d, rd_en_d;
  logic [STRB_W-1:0]   wr_strb_d;
  logic [DATA_W-1:0]   wr_data_d, prdata_d;
  assign setup = apb.psel & ~apb.penable;
  // In IDLE the live bus is decoded so the zero-wait case can enter DONE straight from setup
  assign idx   = state == IDLE ? IDX_W'(apb.paddr >> LSB) : idx_q;
  assign wr    = state == IDLE ? apb.pwrite : wr_q;
  assign wdata = state == IDLE ? apb.pwdata : wdata_q;
  assign strb  = state == IDLE ? apb.pstrb : strb_q;
  always_comb begin
    sel = '0;
    for (int i = 0; i < REG_NUM; i++) sel[i] = 32'(idx) == i;
  end
  assign err = ~|sel | (wr & |(sel & RO_MASK));
  gmux_one_hot_cfg #(.DATA_W(DATA_W), .N(REG_NUM)) u_mux (
    .sel  (sel),
    .din  (regs_port),
    .dout (rdata)
  );
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state <= next;
      if (state == IDLE && setup) begin
        cnt     <= CNT_W'(WAIT_CYC);
        idx_q   <= idx;
        wr_q    <= wr;
        wdata_q <= wdata;
        strb_q  <= strb;
      end else if (state == WAIT) cnt <= cnt - 1'b1;
    end
  always_comb begin
    next = state == IDLE ? (setup ? (WAIT_CYC == 0 ? DONE : WAIT) : IDLE)
         : state == WAIT ? (!apb.psel ? IDLE : cnt == CNT_W'(1) ? DONE : WAIT)
         : IDLE;
  end
  // Disabled errors still suppress the access; only the pslverr flag is dropped
  always_comb begin
    pready_d  = next == DONE;
    acc       = pready_d & ~err;
    pslverr_d = pready_d & err & ERR_EN;
    wr_en_d   = {REG_NUM{acc & wr}} & sel;
    rd_en_d   = {REG_NUM{acc & ~wr}} & sel;
    wr_strb_d = (acc & wr) ? strb : '0;
    wr_data_d = (acc & wr) ? wdata : '0;
    prdata_d  = (acc & ~wr) ? rdata : '0;
  end
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      apb.pready   <= 1'b0;
      apb.pslverr  <= 1'b0;
      apb.prdata   <= '0;
      reg_wr_en    <= '0;
      reg_rd_en    <= '0;
      reg_wr_strb  <= '0;
      reg_wr_data  <= '0;
    end else begin
      apb.pready   <= pready_d;
      apb.pslverr  <= pslverr_d;
      reg_wr_en    <= wr_en_d;
      reg_rd_en    <= rd_en_d;
      reg_wr_strb  <= wr_strb_d;
      reg_wr_data  <= wr_data_d;
      if (pready_d) apb.prdata <= prdata_d;
    end
endmodule

// File: tb/tb_gapb4_regs_if.sv
// tb_gapb4_regs_if: directed checks of three gapb4_regs_if configurations (0, 3 and 4 wait states)
module tb_gapb4_regs_if;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 pclk = ~pclk;
  gapb4_regs_if_if #(.ADDR_W(6), .DATA_W(32)) a0 ();
  gapb4_regs_if_if #(.ADDR_W(6), .DATA_W(32)) a3 ();
  gapb4_regs_if_if #(.ADDR_W(6), .DATA_W(32)) a4 ();
  logic [255:0] regs0, regs3, regs4;
  logic [7:0]  wr_en0, rd_en0, wr_en3, rd_en3, wr_en4, rd_en4;
  logic [3:0]  strb0, strb3, strb4;
  logic [31:0] wdat0, wdat3, wdat4;
  gapb4_regs_if #(.WAIT_CYC(0), .RO_MASK(8'h01)) d0 (
    .pclk(pclk), .rst(rst), .apb(a0), .regs_port(regs0),
    .reg_wr_en(wr_en0), .reg_wr_strb(strb0), .reg_wr_data(wdat0), .reg_rd_en(rd_en0));
  gapb4_regs_if #(.WAIT_CYC(3)) d3 (
    .pclk(pclk), .rst(rst), .apb(a3), .regs_port(regs3),
    .reg_wr_en(wr_en3), .reg_wr_strb(strb3), .reg_wr_data(wdat3), .reg_rd_en(rd_en3));
  gapb4_regs_if #(.WAIT_CYC(4), .ERR_EN(1'b0)) d4 (
    .pclk(pclk), .rst(rst), .apb(a4), .regs_port(regs4),
    .reg_wr_en(wr_en4), .reg_wr_strb(strb4), .reg_wr_data(wdat4), .reg_rd_en(rd_en4));
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask
  task automatic setup0(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    a0.psel = 1'b1; a0.penable = 1'b0; a0.pwrite = w; a0.paddr = a; a0.pwdata = d; a0.pstrb = s;
  endtask
  task automatic setup3(input logic [5:0] a);
    a3.psel = 1'b1; a3.penable = 1'b0; a3.pwrite = 1'b0; a3.paddr = a; a3.pwdata = '0; a3.pstrb = '0;
  endtask
  task automatic setup4(input logic [5:0] a);
    a4.psel = 1'b1; a4.penable = 1'b0; a4.pwrite = 1'b0; a4.paddr = a; a4.pwdata = '0; a4.pstrb = '0;
  endtask
  task automatic test_reset();
    cyc(); cyc();
    checks++; if (a0.pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %0h exp 0", a0.pready); end
    checks++; if (a0.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %0h exp 0", a0.pslverr); end
    checks++; if (a0.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got %0h exp 0", a0.prdata); end
    checks++; if (wr_en0 !== 8'h0) begin errors++; $display("FAIL reset_wr_en got %0h exp 0", wr_en0); end
    checks++; if (rd_en0 !== 8'h0) begin errors++; $display("FAIL reset_rd_en got %0h exp 0", rd_en0); end
    checks++; if (strb0 !== 4'h0) begin errors++; $display("FAIL reset_wr_strb got %0h exp 0", strb0); end
    checks++; if (wdat0 !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %0h exp 0", wdat0); end
    rst = 1'b0;
    cyc();
  endtask
  task automatic test_write();
    setup0(1'b1, 6'h08, 32'hDEADBEEF, 4'hF);
    cyc();
    checks++; if (a0.pready !== 1'b1) begin errors++; $display("FAIL write_pready got %0h exp 1", a0.pready); end
    checks++; if (a0.pslverr !== 1'b0) begin errors++; $display("FAIL write_pslverr got %0h exp 0", a0.pslverr); end
    checks++; if (wr_en0 !== 8'h04) begin errors++; $display("FAIL write_wr_en got %0h exp 04", wr_en0); end
    checks++; if (wdat0 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data got %0h exp deadbeef", wdat0); end
    checks++; if (strb0 !== 4'hF) begin errors++; $display("FAIL write_strb got %0h exp f", strb0); end
    checks++; if (rd_en0 !== 8'h00) begin errors++; $display("FAIL write_rd_en got %0h exp 0", rd_en0); end
    a0.penable = 1'b1;
    cyc();
    a0.psel = 1'b0; a0.penable = 1'b0;
    checks++; if (a0.pready !== 1'b0) begin errors++; $display("FAIL write_pready_after got %0h exp 0", a0.pready); end
    checks++; if (wr_en0 !== 8'h00) begin errors++; $display("FAIL write_wr_en_after got %0h exp 0", wr_en0); end
    checks++; if (wdat0 !== 32'h0) begin errors++; $display("FAIL write_data_after got %0h exp 0", wdat0); end
    cyc();
  endtask
  task automatic test_strobe();
    setup0(1'b1, 6'h05, 32'hA5A5A5A5, 4'b0101);
    cyc();
    checks++; if (strb0 !== 4'b0101) begin errors++; $display("FAIL strobe_strb got %0h exp 5", strb0); end
    checks++; if (wr_en0 !== 8'h02) begin errors++; $display("FAIL strobe_wr_en got %0h exp 02", wr_en0); end
    checks++; if (wdat0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL strobe_data got %0h exp a5a5a5a5", wdat0); end
    a0.penable = 1'b1;
    cyc();
    a0.psel = 1'b0; a0.penable = 1'b0;
    cyc();
  endtask
  task automatic test_back_to_back();
    setup0(1'b1, 6'h08, 32'h0BADF00D, 4'hF);
    cyc();
    checks++; if (a0.pready !== 1'b1) begin errors++; $display("FAIL b2b_pready1 got %0h exp 1", a0.pready); end
    checks++; if (wr_en0 !== 8'h04) begin errors++; $display("FAIL b2b_wr_en got %0h exp 04", wr_en0); end
    a0.penable = 1'b1;
    cyc();
    checks++; if (a0.pready !== 1'b0) begin errors++; $display("FAIL b2b_gap got %0h exp 0", a0.pready); end
    setup0(1'b0, 6'h0C, 32'h0, 4'h0);
    cyc();
    checks++; if (a0.pready !== 1'b1) begin errors++; $display("FAIL b2b_pready2 got %0h exp 1", a0.pready); end
    checks++; if (rd_en0 !== 8'h08) begin errors++; $display("FAIL b2b_rd_en got %0h exp 08", rd_en0); end
    checks++; if (wr_en0 !== 8'h00) begin errors++; $display("FAIL b2b_wr_en2 got %0h exp 0", wr_en0); end
    checks++; if (a0.prdata !== 32'h44444444) begin errors++; $display("FAIL b2b_prdata got %0h exp 44444444", a0.prdata); end
    a0.penable = 1'b1;
    cyc();
    a0.psel = 1'b0; a0.penable = 1'b0;
    checks++; if (a0.prdata !== 32'h44444444) begin errors++; $display("FAIL b2b_prdata_hold got %0h exp 44444444", a0.prdata); end
    cyc();
  endtask
  task automatic test_errors();
    setup0(1'b0, 6'h20, 32'h0, 4'h0);
    cyc();
    checks++; if (a0.pready !== 1'b1) begin errors++; $display("FAIL unmapped_pready got %0h exp 1", a0.pready); end
    checks++; if (a0.pslverr !== 1'b1) begin errors++; $display("FAIL unmapped_pslverr got %0h exp 1", a0.pslverr); end
    checks++; if (a0.prdata !== 32'h0) begin errors++; $display("FAIL unmapped_prdata got %0h exp 0", a0.prdata); end
    checks++; if (rd_en0 !== 8'h00) begin errors++; $display("FAIL unmapped_rd_en got %0h exp 0", rd_en0); end
    a0.penable = 1'b1;
    cyc();
    setup0(1'b1, 6'h00, 32'hFFFFFFFF, 4'hF);
    cyc();
    checks++; if (a0.pslverr !== 1'b1) begin errors++; $display("FAIL ro_pslverr got %0h exp 1", a0.pslverr); end
    checks++; if (wr_en0 !== 8'h00) begin errors++; $display("FAIL ro_wr_en got %0h exp 0", wr_en0); end
    checks++; if (strb0 !== 4'h0) begin errors++; $display("FAIL ro_wr_strb got %0h exp 0", strb0); end
    a0.penable = 1'b1;
    cyc();
    a0.psel = 1'b0; a0.penable = 1'b0;
    checks++; if (a0.pslverr !== 1'b0) begin errors++; $display("FAIL ro_pslverr_after got %0h exp 0", a0.pslverr); end
    cyc();
  endtask
  task automatic test_read_wait();
    setup3(6'h14);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) begin a3.penable = 1'b1; a3.paddr = 6'h00; a3.pwrite = 1'b1; end
      checks++; if (a3.pready !== (k == 4)) begin errors++; $display("FAIL wait_pready_c%0d got %0h exp %0h", k + 1, a3.pready, k == 4); end
      if (k == 4) begin
        checks++; if (a3.prdata !== 32'h12345678) begin errors++; $display("FAIL wait_prdata got %0h exp 12345678", a3.prdata); end
        checks++; if (rd_en3 !== 8'h20) begin errors++; $display("FAIL wait_rd_en got %0h exp 20", rd_en3); end
        checks++; if (wr_en3 !== 8'h00) begin errors++; $display("FAIL wait_wr_en got %0h exp 0", wr_en3); end
      end
    end
    a3.psel = 1'b0; a3.penable = 1'b0;
    cyc();
  endtask
  task automatic test_abort();
    setup4(6'h08);
    cyc();
    a4.penable = 1'b1;
    cyc();
    a4.psel = 1'b0; a4.penable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (a4.pready !== 1'b0 || rd_en4 !== 8'h00) begin errors++; $display("FAIL abort_quiet c%0d got pready %0h rd_en %0h exp 0 0", k, a4.pready, rd_en4); end
    end
    setup4(6'h08);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) a4.penable = 1'b1;
    end
    checks++; if (a4.pready !== 1'b1) begin errors++; $display("FAIL abort_recover_pready got %0h exp 1", a4.pready); end
    checks++; if (rd_en4 !== 8'h04) begin errors++; $display("FAIL abort_recover_rd_en got %0h exp 04", rd_en4); end
    checks++; if (a4.prdata !== 32'hC0DE0002) begin errors++; $display("FAIL abort_recover_prdata got %0h exp c0de0002", a4.prdata); end
    cyc();
    a4.psel = 1'b0; a4.penable = 1'b0;
    cyc();
  endtask
  task automatic test_reset_mid();
    setup4(6'h04);
    cyc();
    a4.penable = 1'b1;
    cyc();
    #2 rst = 1'b1;
    #1;
    checks++; if (a4.prdata !== 32'h0) begin errors++; $display("FAIL rstmid_prdata4 got %0h exp 0", a4.prdata); end
    checks++; if (a3.prdata !== 32'h0) begin errors++; $display("FAIL rstmid_prdata3 got %0h exp 0", a3.prdata); end
    checks++; if (a0.prdata !== 32'h0) begin errors++; $display("FAIL rstmid_prdata0 got %0h exp 0", a0.prdata); end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++; if (a4.pready !== 1'b0 || rd_en4 !== 8'h00) begin errors++; $display("FAIL rstmid_quiet c%0d got pready %0h rd_en %0h exp 0 0", k, a4.pready, rd_en4); end
    end
    a4.psel = 1'b0; a4.penable = 1'b0;
    cyc();
  endtask
  task automatic test_err_disabled();
    setup4(6'h3C);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) a4.penable = 1'b1;
    end
    checks++; if (a4.pready !== 1'b1) begin errors++; $display("FAIL errdis_pready got %0h exp 1", a4.pready); end
    checks++; if (a4.pslverr !== 1'b0) begin errors++; $display("FAIL errdis_pslverr got %0h exp 0", a4.pslverr); end
    checks++; if (rd_en4 !== 8'h00) begin errors++; $display("FAIL errdis_rd_en got %0h exp 0", rd_en4); end
    cyc();
    a4.psel = 1'b0; a4.penable = 1'b0;
    cyc();
  endtask
  initial begin
    a0.psel = 0; a0.penable = 0; a0.pwrite = 0; a0.paddr = '0; a0.pwdata = '0; a0.pstrb = '0;
    a3.psel = 0; a3.penable = 0; a3.pwrite = 0; a3.paddr = '0; a3.pwdata = '0; a3.pstrb = '0;
    a4.psel = 0; a4.penable = 0; a4.pwrite = 0; a4.paddr = '0; a4.pwdata = '0; a4.pstrb = '0;
    for (int r = 0; r < 8; r++) begin
      regs0[r*32 +: 32] = 32'h11111111 * (r + 1);
      regs3[r*32 +: 32] = 32'hA0000000 + r;
      regs4[r*32 +: 32] = 32'hC0DE0000 + r;
    end
    regs3[5*32 +: 32] = 32'h12345678;
    test_reset();
    test_write();
    test_strobe();
    test_back_to_back();
    test_errors();
    test_read_wait();
    test_abort();
    test_reset_mid();
    test_err_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
